// File: rtl/cmd_reg_slave_if.sv
// Command bus between a host and a register slave: one request per sel,
// answered later by a single-cycle ack carrying rdata.
interface intf_cmd #(
   parameter int ADDR_BITS = 24
);
   logic                 sel;
   logic                 rd_wr_n;
   logic [ADDR_BITS-1:0] byte_addr;
   logic [31:0]          wdata;
   logic                 ack;
   logic [31:0]          rdata;

   modport slave (
      input  sel, rd_wr_n, byte_addr, wdata,
      output ack, rdata
   );

   modport master (
      output sel, rd_wr_n, byte_addr, wdata,
      input  ack, rdata
   );
endinterface

// File: rtl/cmd_reg_slave.sv
// Register slave on the cmd bus: RW control words, RO status words, a sticky
// event register with W1C, an interrupt mask and a constant version word.
module cmd_reg_slave #(
   parameter int          CMD_ADDR_BITS      = 24,
   parameter int          CMD_DATA_BITS      = 32,
   parameter int          NUM_RW_REGS        = 8,
   parameter int          NUM_RO_REGS        = 8,
   parameter int          ACK_LATENCY_CLKS   = 1,
   parameter logic [31:0] RW_RESET_VALUE     = 32'h0,
   parameter logic [31:0] VERSION            = 32'h0001_0000,
   parameter bit          RESPOND_TO_INVALID = 1'b1
) (
   input  logic                       i_sysclk,
   input  logic                       i_srst_n,
   intf_cmd.slave                     cmd,
   output logic [NUM_RW_REGS*32-1:0]  o_rw_regs,
   input  logic [NUM_RO_REGS*32-1:0]  i_ro_regs,
   input  logic [31:0]                i_events,
   output logic                       o_irq
);

   localparam int WB       = CMD_ADDR_BITS - 2;
   localparam int E_WORD   = NUM_RW_REGS + NUM_RO_REGS;
   localparam logic [WB-1:0] W_EVENTS  = WB'(E_WORD);
   localparam logic [WB-1:0] W_MASK    = WB'(E_WORD + 1);
   localparam logic [WB-1:0] W_VERSION = WB'(E_WORD + 2);
   localparam logic [3:0]    LAT_LAST  = 4'(ACK_LATENCY_CLKS - 1);
   localparam logic [CMD_DATA_BITS-1:0] INVALID_RDATA = CMD_DATA_BITS'(32'hBADA_DD00);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                   state;
   logic [3:0]               lat_cnt;
   logic                     cap_rd;
   logic [WB-1:0]            cap_w;
   logic [CMD_DATA_BITS-1:0] cap_wdata;
   logic                     ack_q;
   logic [CMD_DATA_BITS-1:0] rdata_q;

   logic [CMD_DATA_BITS-1:0] rw_q [NUM_RW_REGS];
   logic [CMD_DATA_BITS-1:0] events_q;
   logic [CMD_DATA_BITS-1:0] mask_q;
   logic                     irq_q;

   logic [CMD_DATA_BITS-1:0] rd_val;
   logic                     addr_valid;
   logic                     wr_fire;
   logic [CMD_DATA_BITS-1:0] events_clr;
   logic                     unused_addr_bits;

   assign unused_addr_bits = ^cmd.byte_addr[1:0];

   // Decode the captured word index into a read value and a hit flag.
   always_comb begin
      rd_val     = '0;
      addr_valid = 1'b0;
      for (int k = 0; k < NUM_RW_REGS; k++) begin
         if (cap_w == WB'(k)) begin
            rd_val     = rw_q[k];
            addr_valid = 1'b1;
         end
      end
      for (int k = 0; k < NUM_RO_REGS; k++) begin
         if (cap_w == WB'(NUM_RW_REGS + k)) begin
            rd_val     = i_ro_regs[32*k +: 32];
            addr_valid = 1'b1;
         end
      end
      if (cap_w == W_EVENTS) begin
         rd_val     = events_q;
         addr_valid = 1'b1;
      end
      if (cap_w == W_MASK) begin
         rd_val     = mask_q;
         addr_valid = 1'b1;
      end
      if (cap_w == W_VERSION) begin
         rd_val     = VERSION;
         addr_valid = 1'b1;
      end
   end

   assign wr_fire    = (state == RESP) && !cap_rd && addr_valid;
   assign events_clr = (wr_fire && (cap_w == W_EVENTS)) ? cap_wdata : '0;

   always_ff @(posedge i_sysclk) begin
      if (!i_srst_n) begin
         state     <= IDLE;
         lat_cnt   <= 4'd0;
         cap_rd    <= 1'b0;
         cap_w     <= '0;
         cap_wdata <= '0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd.sel) begin
                  cap_rd    <= cmd.rd_wr_n;
                  cap_w     <= cmd.byte_addr[CMD_ADDR_BITS-1:2];
                  cap_wdata <= cmd.wdata;
                  if (ACK_LATENCY_CLKS == 1) begin
                     state <= RESP;
                  end else begin
                     state   <= WAIT;
                     lat_cnt <= 4'd1;
                  end
               end
            end
            WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  state <= RESP;
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
               end
            end
            RESP: begin
               // Invalid words without RESPOND_TO_INVALID leave ack and rdata untouched.
               state   <= IDLE;
               lat_cnt <= 4'd0;
               if (addr_valid) begin
                  ack_q   <= 1'b1;
                  rdata_q <= cap_rd ? rd_val : '0;
               end else if (RESPOND_TO_INVALID) begin
                  ack_q   <= 1'b1;
                  rdata_q <= INVALID_RDATA;
               end
            end
            default: begin
               state   <= IDLE;
               lat_cnt <= 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge i_sysclk) begin
      if (!i_srst_n) begin
         for (int k = 0; k < NUM_RW_REGS; k++) begin
            rw_q[k] <= RW_RESET_VALUE;
         end
         mask_q   <= '0;
         events_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_RW_REGS; k++) begin
            if (wr_fire && (cap_w == WB'(k))) begin
               rw_q[k] <= cap_wdata;
            end
         end
         if (wr_fire && (cap_w == W_MASK)) begin
            mask_q <= cap_wdata;
         end
         // A new pulse wins over a clear on the same bit.
         events_q <= (events_q & ~events_clr) | i_events;
         irq_q    <= |(events_q & mask_q);
      end
   end

   for (genvar k = 0; k < NUM_RW_REGS; k++) begin : g_rw_out
      assign o_rw_regs[32*k +: 32] = rw_q[k];
   end

   assign cmd.ack   = ack_q;
   assign cmd.rdata = rdata_q;
   assign o_irq     = irq_q;

endmodule

// File: tb/tb_cmd_reg_slave.sv
// Scoreboard bench: dut_a (latency 3, acks invalid) and dut_b (latency 4,
// silent on invalid, non-zero RW reset value) driven with directed vectors.
module tb_cmd_reg_slave;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      longint      t0;
      int          lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] rw_a, rw_b;
   logic [255:0] ro_a = '0;
   logic [255:0] ro_b = '0;
   logic [31:0]  ev_a = '0;
   logic [31:0]  ev_b = '0;
   logic         irq_a, irq_b;

   int checks = 0;
   int errors = 0;
   int ack_cnt_a = 0;
   int ack_cnt_b = 0;
   int cnt0;
   exp_t q_a[$];
   exp_t q_b[$];

   intf_cmd #(.ADDR_BITS(24)) cmd_a ();
   intf_cmd #(.ADDR_BITS(24)) cmd_b ();

   always #5 clk = ~clk;

   cmd_reg_slave #(
      .ACK_LATENCY_CLKS(3)
   ) dut_a (
      .i_sysclk(clk), .i_srst_n(rst_n), .cmd(cmd_a.slave),
      .o_rw_regs(rw_a), .i_ro_regs(ro_a), .i_events(ev_a), .o_irq(irq_a)
   );

   cmd_reg_slave #(
      .ACK_LATENCY_CLKS(4),
      .RW_RESET_VALUE(32'h5A5A_0000),
      .RESPOND_TO_INVALID(1'b0)
   ) dut_b (
      .i_sysclk(clk), .i_srst_n(rst_n), .cmd(cmd_b.slave),
      .o_rw_regs(rw_b), .i_ro_regs(ro_b), .i_events(ev_b), .o_irq(irq_b)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drives one request; the sel-sampling edge is the latency reference.
   task automatic applyStimulus(input bit which, input string name, input bit rd,
                                input logic [23:0] addr, input logic [31:0] wd,
                                input bit expect_ack, input logic [31:0] exp_rdata);
      exp_t e;
      @(posedge clk);
      #1;
      if (which) begin
         cmd_b.sel = 1'b1; cmd_b.rd_wr_n = rd; cmd_b.byte_addr = addr; cmd_b.wdata = wd;
      end else begin
         cmd_a.sel = 1'b1; cmd_a.rd_wr_n = rd; cmd_a.byte_addr = addr; cmd_a.wdata = wd;
      end
      @(posedge clk);
      if (expect_ack) begin
         e.name  = name;
         e.rdata = exp_rdata;
         e.t0    = longint'($time);
         e.lat   = which ? 45 : 35;
         if (which) q_b.push_back(e);
         else       q_a.push_back(e);
      end
      #1;
      if (which) cmd_b.sel = 1'b0;
      else       cmd_a.sel = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (cmd_a.ack === 1'b1) begin
         ack_cnt_a++;
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack_a: got ack with rdata %h, expected none", cmd_a.rdata);
         end else begin
            e = q_a.pop_front();
            checkOutput({e.name, "_rdata"}, cmd_a.rdata, e.rdata);
            checkOutput({e.name, "_lat"}, 32'(longint'($time) - e.t0), 32'(e.lat));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (cmd_b.ack === 1'b1) begin
         ack_cnt_b++;
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack_b: got ack with rdata %h, expected none", cmd_b.rdata);
         end else begin
            e = q_b.pop_front();
            checkOutput({e.name, "_rdata"}, cmd_b.rdata, e.rdata);
            checkOutput({e.name, "_lat"}, 32'(longint'($time) - e.t0), 32'(e.lat));
         end
      end
   end

   initial begin
      cmd_a.sel = 1'b0; cmd_a.rd_wr_n = 1'b0; cmd_a.byte_addr = '0; cmd_a.wdata = '0;
      cmd_b.sel = 1'b0; cmd_b.rd_wr_n = 1'b0; cmd_b.byte_addr = '0; cmd_b.wdata = '0;
      ro_a[31:0] = 32'h1234_5678;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_ack_a", {31'b0, cmd_a.ack}, 32'h0);
      checkOutput("rst_rdata_a", cmd_a.rdata, 32'h0);
      checkOutput("rst_irq_a", {31'b0, irq_a}, 32'h0);
      checkOutput("rst_rw_a_w0", rw_a[31:0], 32'h0);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("rst_rw_b_w%0d", k), rw_b[32*k +: 32], 32'h5A5A_0000);
      end
      rst_n = 1'b1;
      settle(2);

      // Write/read word 1 with latency 3
      applyStimulus(1'b0, "wr_w1_a", 1'b0, 24'h000004, 32'hA5A5_0001, 1'b1, 32'h0);
      settle(6);
      checkOutput("rw_a_w1", rw_a[63:32], 32'hA5A5_0001);
      applyStimulus(1'b0, "rd_w1_a", 1'b1, 24'h000007, 32'h0, 1'b1, 32'hA5A5_0001);
      settle(6);

      // RO word, VERSION write-then-read, invalid address
      applyStimulus(1'b0, "rd_ro0_a", 1'b1, 24'h000020, 32'h0, 1'b1, 32'h1234_5678);
      settle(6);
      applyStimulus(1'b0, "wr_ver_a", 1'b0, 24'h000048, 32'hDEAD_BEEF, 1'b1, 32'h0);
      settle(6);
      applyStimulus(1'b0, "rd_ver_a", 1'b1, 24'h000048, 32'h0, 1'b1, 32'h0001_0000);
      settle(6);
      applyStimulus(1'b0, "rd_inv_a", 1'b1, 24'hFFFFFC, 32'h0, 1'b1, 32'hBADA_DD00);
      settle(6);

      // Event bit 3 with mask clear
      @(posedge clk); #1 ev_a = 32'h8;
      @(posedge clk); #1 ev_a = 32'h0;
      settle(2);
      checkOutput("irq_masked", {31'b0, irq_a}, 32'h0);
      applyStimulus(1'b0, "rd_ev_a", 1'b1, 24'h000040, 32'h0, 1'b1, 32'h8);
      settle(6);

      // Mask write: irq follows one clock after the ack edge
      applyStimulus(1'b0, "wr_mask_a", 1'b0, 24'h000044, 32'h8, 1'b1, 32'h0);
      #34;
      checkOutput("irq_lag", {31'b0, irq_a}, 32'h0);
      #10;
      checkOutput("irq_set", {31'b0, irq_a}, 32'h1);
      settle(3);

      // Clear coincident with a new pulse keeps the bit
      applyStimulus(1'b0, "wr_clr_pulse_a", 1'b0, 24'h000040, 32'h8, 1'b1, 32'h0);
      #20 ev_a = 32'h8;
      #10 ev_a = 32'h0;
      settle(4);
      checkOutput("irq_after_race", {31'b0, irq_a}, 32'h1);
      applyStimulus(1'b0, "rd_ev_race_a", 1'b1, 24'h000040, 32'h0, 1'b1, 32'h8);
      settle(6);

      // Clear alone
      applyStimulus(1'b0, "wr_clr_a", 1'b0, 24'h000040, 32'h8, 1'b1, 32'h0);
      settle(6);
      checkOutput("irq_cleared", {31'b0, irq_a}, 32'h0);
      applyStimulus(1'b0, "rd_ev_clr_a", 1'b1, 24'h000040, 32'h0, 1'b1, 32'h0);
      settle(6);

      // Busy: second sel two clocks after the first is dropped
      cnt0 = ack_cnt_b;
      applyStimulus(1'b1, "wr_w1_b", 1'b0, 24'h000004, 32'h1111_1111, 1'b1, 32'h0);
      @(posedge clk); #1;
      cmd_b.sel = 1'b1; cmd_b.rd_wr_n = 1'b0; cmd_b.byte_addr = 24'h000008; cmd_b.wdata = 32'h2222_2222;
      @(posedge clk); #1;
      cmd_b.sel = 1'b0;
      settle(8);
      checkOutput("busy_ack_count", 32'(ack_cnt_b - cnt0), 32'd1);
      checkOutput("busy_rw_b_w1", rw_b[63:32], 32'h1111_1111);
      checkOutput("busy_rw_b_w2", rw_b[95:64], 32'h5A5A_0000);

      // Invalid address on the silent instance, then a valid access
      cnt0 = ack_cnt_b;
      applyStimulus(1'b1, "rd_inv_b", 1'b1, 24'hFFFFFC, 32'h0, 1'b0, 32'h0);
      settle(20);
      checkOutput("inv_b_no_ack", 32'(ack_cnt_b - cnt0), 32'd0);
      applyStimulus(1'b1, "rd_ver_b", 1'b1, 24'h000048, 32'h0, 1'b1, 32'h0001_0000);
      settle(8);

      // Reset between sel and ack discards the write
      cnt0 = ack_cnt_a;
      applyStimulus(1'b0, "wr_rst_a", 1'b0, 24'h000000, 32'hFFFF_FFFF, 1'b0, 32'h0);
      #10 rst_n = 1'b0;
      #10 rst_n = 1'b1;
      settle(6);
      checkOutput("rst_mid_no_ack", 32'(ack_cnt_a - cnt0), 32'd0);
      checkOutput("rst_mid_rw_a_w0", rw_a[31:0], 32'h0);
      applyStimulus(1'b0, "rd_w0_after_rst_a", 1'b1, 24'h000000, 32'h0, 1'b1, 32'h0);
      settle(6);

      checkOutput("pending_a", 32'(q_a.size()), 32'd0);
      checkOutput("pending_b", 32'(q_b.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
